// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit, valid/ready on both sides, 1-cycle latency.
// Define LOGIC_UNIT_PARITY_EN to add the registered even-parity output.
module logic_unit_pipe #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             op_err,
`ifdef LOGIC_UNIT_PARITY_EN
   output logic             parity,
`endif
   output logic [CNT_W-1:0] txn_count
);

   logic [WIDTH-1:0] f;
   logic             accept;

   // A stalled output blocks new beats; a draining one lets the next in.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      f = '0;
      unique case (1'b1)
         op == 3'b000: f = a & b;
         op == 3'b001: f = a | b;
         op == 3'b010: f = a ^ b;
         op == 3'b011: f = ~(a | b);
         op == 3'b100: f = ~(a & b);
         op == 3'b101: f = ~(a ^ b);
         op == 3'b110: f = a & ~b;
         default:      f = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         op_err    <= 1'b0;
         txn_count <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= f;
         zero      <= ~|f;
         op_err    <= (op == 3'b111);
         txn_count <= txn_count + CNT_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef LOGIC_UNIT_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity <= 1'b0;
      end else if (accept) begin
         parity <= ^f;
      end
   end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe.
// A second CNT_W=2 instance shares the inputs to exercise counter wrap.
module tb_logic_unit_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready2;
   logic [2:0]  op = 3'b000;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid, out_valid2;
   logic        out_ready = 1'b1;
   logic [31:0] result, result2;
   logic        zero, zero2;
   logic        op_err, op_err2;
   logic [15:0] txn_count;
   logic [1:0]  txn_count2;
`ifdef LOGIC_UNIT_PARITY_EN
   logic        parity, parity2;
`endif

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .op_err(op_err),
`ifdef LOGIC_UNIT_PARITY_EN
      .parity(parity),
`endif
      .txn_count(txn_count)
   );

   logic_unit_pipe #(.WIDTH(32), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready),
      .result(result2), .zero(zero2), .op_err(op_err2),
`ifdef LOGIC_UNIT_PARITY_EN
      .parity(parity2),
`endif
      .txn_count(txn_count2)
   );

   function automatic logic [31:0] model(input logic [2:0] o,
                                         input logic [31:0] x,
                                         input logic [31:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x ^ y;
         3'd3: return ~(x | y);
         3'd4: return ~(x & y);
         3'd5: return ~(x ^ y);
         3'd6: return x & ~y;
         default: return 32'h0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; op = 3'b001; a = 32'h5; b = 32'h3;
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 32'h7) begin
         bad++;
         $display("FAIL pre_reset_beat: valid=%b result=%h need 1/00000007",
                  out_valid, result);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1 ||
          op_err !== 1'b0 || txn_count !== 16'h0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL async_reset: v=%b r=%h z=%b e=%b c=%0d rdy=%b",
                  out_valid, result, zero, op_err, txn_count, in_ready);
      end
      step();
      rst_n = 1'b1;
      exp_cnt = 0;
      step();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL idle: v=%b rdy=%b need 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_ops();
      logic [31:0] exp_r [7];
      exp_r = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34, 32'h000F_00CB,
                32'hFF0F_EDFF, 32'h00FF_12CB, 32'hF000_0034};
      out_ready = 1'b1;
      a = 32'hF0F0_1234; b = 32'h0FF0_FF00;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         op = 3'(i);
         step();
         exp_cnt++;
         total++;
         if (out_valid !== 1'b1 || result !== exp_r[i] || zero !== 1'b0 ||
             op_err !== 1'b0) begin
            bad++;
            $display("FAIL op_%0d: v=%b r=%h z=%b e=%b need 1/%h/0/0",
                     i, out_valid, result, zero, op_err, exp_r[i]);
         end
      end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || result !== 32'hF000_0034 ||
          txn_count !== 16'd7) begin
         bad++;
         $display("FAIL op_drain: v=%b r=%h c=%0d need 0/f0000034/7",
                  out_valid, result, txn_count);
      end
   endtask

   task automatic test_reserved_zero();
      in_valid = 1'b1; op = 3'b111; a = '1; b = '1;
      step();
      exp_cnt++;
      total++;
      if (result !== 32'h0 || zero !== 1'b1 || op_err !== 1'b1) begin
         bad++;
         $display("FAIL reserved: r=%h z=%b e=%b need 0/1/1",
                  result, zero, op_err);
      end
      op = 3'b000; a = 32'h1; b = 32'h1;
      step();
      exp_cnt++;
      total++;
      if (result !== 32'h1 || zero !== 1'b0 || op_err !== 1'b0) begin
         bad++;
         $display("FAIL after_reserved: r=%h z=%b e=%b need 1/0/0",
                  result, zero, op_err);
      end
      b = 32'h2;
      step();
      exp_cnt++;
      total++;
      if (result !== 32'h0 || zero !== 1'b1 || op_err !== 1'b0) begin
         bad++;
         $display("FAIL zero_flag: r=%h z=%b e=%b need 0/1/0",
                  result, zero, op_err);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      logic [31:0] av [4];
      av = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
      op = 3'b001; b = 32'h0000_00AA;
      out_ready = 1'b0;
      in_valid = 1'b1;
      a = av[0];
      step();
      exp_cnt++;
      for (int i = 1; i < 4; i++) begin
         a = av[i];
         total++;
         if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready_%0d: rdy=%b need 0", i, in_ready);
         end
         step();
         total++;
         if (out_valid !== 1'b1 || result !== (av[0] | b) ||
             txn_count !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL stall_hold_%0d: v=%b r=%h c=%0d need 1/%h/%0d",
                     i, out_valid, result, txn_count, av[0] | b, exp_cnt);
         end
      end
      out_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         a = av[i];
         step();
         exp_cnt++;
         total++;
         if (out_valid !== 1'b1 || result !== (av[i] | b)) begin
            bad++;
            $display("FAIL release_%0d: v=%b r=%h need 1/%h",
                     i, out_valid, result, av[i] | b);
         end
      end
      in_valid = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || txn_count !== 16'(exp_cnt)) begin
         bad++;
         $display("FAIL bp_end: v=%b c=%0d need 0/%0d",
                  out_valid, txn_count, exp_cnt);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] e;
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         op = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         e = model(op, a, b);
         step();
         exp_cnt++;
         total++;
         if (out_valid !== 1'b1 || result !== e || zero !== (e == 0) ||
             op_err !== (op == 3'b111) || result2 !== e ||
             txn_count !== 16'(exp_cnt) || txn_count2 !== 2'(exp_cnt)) begin
            bad++;
            $display("FAIL stream_%0d: v=%b r=%h r2=%h c=%0d c2=%0d need %h/%0d",
                     i, out_valid, result, result2, txn_count, txn_count2,
                     e, exp_cnt);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_stall();
      out_ready = 1'b0;
      in_valid = 1'b1; op = 3'b001; a = 32'h7; b = 32'h3;
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || result !== 32'h7) begin
         bad++;
         $display("FAIL stall_setup: v=%b r=%h need 1/00000007",
                  out_valid, result);
      end
`ifdef LOGIC_UNIT_PARITY_EN
      total++;
      if (parity !== 1'b1) begin
         bad++;
         $display("FAIL parity: got %b need 1", parity);
      end
`endif
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || txn_count !== 16'h0 || txn_count2 !== 2'h0 ||
          result !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_stall: v=%b c=%0d c2=%0d r=%h z=%b",
                  out_valid, txn_count, txn_count2, result, zero);
      end
`ifdef LOGIC_UNIT_PARITY_EN
      total++;
      if (parity !== 1'b0) begin
         bad++;
         $display("FAIL parity_reset: got %b need 0", parity);
      end
`endif
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stale_%0d: v=%b need 0", i, out_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ops();
      test_reserved_zero();
      test_backpressure();
      test_streaming();
      test_reset_stall();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
